// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID/EX hazard controller and its comparator.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hc_state_t;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         MEM_TIMEOUT_DEF = 15;

endpackage

// File: rtl/hc_lu_cmp.sv
// Load-use comparator: flags an ID-stage read of the register a load in EX is about to write.
module hc_lu_cmp
    import hazard_pkg::*;
(
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_rt,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rs,
    input  logic       i_id_uses_rt,
    output logic       o_lu
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = i_id_uses_rs && (i_id_rs == i_ex_rt);
    assign w_rt_hit = i_id_uses_rt && (i_id_rt == i_ex_rt);
    // $zero is never a real dependency, so a load targeting it cannot cause a hazard.
    assign o_lu     = i_ex_memread && (i_ex_rt != REG_ZERO) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, MEM-wait freeze with timeout.
// Optional statistics counters are enabled with the HAZ_STATS_EN macro.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
`ifdef HAZ_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic       clk_HC,
    input  logic       rst_n_HC,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       ex_branch_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       idex_hold,
    output logic       exmem_hold,
    output logic       err
`ifdef HAZ_STATS_EN
    , output logic [CNT_W-1:0] lu_cnt
    , output logic [CNT_W-1:0] flush_cnt
    , output logic [CNT_W-1:0] memwait_cnt
`endif
);

    localparam int              WC_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);

    hc_state_t       r_state;
    hc_state_t       w_state_next;
    logic [WC_W-1:0] r_wait_cnt;
    logic [WC_W-1:0] w_wait_next;
    logic [WC_W-1:0] w_wait_inc;

    logic w_lu;
    logic w_mstall;
    logic w_active;
    logic w_in_err;
    logic w_freeze_mem;
    logic w_flush_fire;
    logic w_lu_fire;

    hc_lu_cmp u_lu_cmp (
        .i_ex_memread (ex_memread),
        .i_ex_rt      (ex_rt),
        .i_id_rs      (id_rs),
        .i_id_rt      (id_rt),
        .i_id_uses_rs (id_uses_rs),
        .i_id_uses_rt (id_uses_rt),
        .o_lu         (w_lu)
    );

    assign w_mstall   = mem_req && !mem_ready;
    assign w_wait_inc = r_wait_cnt + WC_ONE;
    assign w_active   = (r_state == RUN) || (r_state == MEM_WAIT);
    assign w_in_err   = (r_state == ERR);

    // A release cycle out of MEM_WAIT decodes branch/lu exactly like RUN.
    assign w_freeze_mem = w_active && w_mstall;
    assign w_flush_fire = w_active && !w_mstall && ex_branch_taken;
    assign w_lu_fire    = w_active && !w_mstall && !ex_branch_taken && w_lu;

    always_ff @(posedge clk_HC or negedge rst_n_HC) begin
        if (!rst_n_HC) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait_cnt;
        case (r_state)
            RUN, MEM_WAIT: begin
                if (w_mstall) begin
                    // The RUN cycle that first sees the stall is frozen cycle number one.
                    w_wait_next  = (r_state == RUN) ? WC_ONE : w_wait_inc;
                    w_state_next = (w_wait_next == WC_MAX) ? ERR : MEM_WAIT;
                end else begin
                    w_state_next = RUN;
                    w_wait_next  = '0;
                end
            end
            ERR: begin
                w_state_next = ERR;
            end
            default: begin
                w_state_next = RUN;
                w_wait_next  = '0;
            end
        endcase
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_hold   = 1'b0;
        exmem_hold  = 1'b0;
        err         = w_in_err;
        if (w_freeze_mem || w_in_err) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
        end
        if (w_flush_fire) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end
        if (w_lu_fire) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

`ifdef HAZ_STATS_EN
    logic [2:0]            w_cnt_inc;
    logic [2:0][CNT_W-1:0] w_cnt;

    assign w_cnt_inc = {w_freeze_mem, w_flush_fire, w_lu_fire};

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk_HC or negedge rst_n_HC) begin
            if (!rst_n_HC) begin
                r_cnt <= '0;
            end else if (w_cnt_inc[gi] && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign w_cnt[gi] = r_cnt;
    end

    assign lu_cnt      = w_cnt[0];
    assign flush_cnt   = w_cnt[1];
    assign memwait_cnt = w_cnt[2];
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic vs a rule-level model.
module tb_hazard_ctrl;

    localparam int TO = 4;

    // Output vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold, err}
    localparam logic [6:0] IDLE_PAT   = 7'b1100000;
    localparam logic [6:0] LU_PAT     = 7'b0001000;
    localparam logic [6:0] FLUSH_PAT  = 7'b1111000;
    localparam logic [6:0] FREEZE_PAT = 7'b0000110;
    localparam logic [6:0] ERR_PAT    = 7'b0000111;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rs, id_uses_rt, ex_memread, ex_branch_taken;
    logic       mem_req, mem_ready;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold, err;
`ifdef HAZ_STATS_EN
    logic [15:0] lu_cnt, flush_cnt, memwait_cnt;
`endif

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk_HC          (clk),
        .rst_n_HC        (rst_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_memread      (ex_memread),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .idex_hold       (idex_hold),
        .exmem_hold      (exmem_hold),
        .err             (err)
`ifdef HAZ_STATS_EN
        , .lu_cnt        (lu_cnt)
        , .flush_cnt     (flush_cnt)
        , .memwait_cnt   (memwait_cnt)
`endif
    );

    logic [6:0] dut_out;
    assign dut_out = {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold, err};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: consecutive frozen cycles, sticky error flag and event tallies.
    int m_frozen;
    bit m_err;
    int m_lu, m_fl, m_mw;

    function automatic bit model_lu();
        return ex_memread && (ex_rt != 5'd0) &&
               ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    endfunction

    function automatic logic [6:0] exp_out();
        if (m_err)                   return ERR_PAT;
        if (mem_req && !mem_ready)   return FREEZE_PAT;
        if (ex_branch_taken)         return FLUSH_PAT;
        if (model_lu())              return LU_PAT;
        return IDLE_PAT;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_frozen <= 0;
            m_err    <= 1'b0;
            m_lu     <= 0;
            m_fl     <= 0;
            m_mw     <= 0;
        end else if (!m_err) begin
            if (mem_req && !mem_ready) begin
                m_frozen <= m_frozen + 1;
                m_mw     <= m_mw + 1;
                if (m_frozen + 1 >= TO) m_err <= 1'b1;
            end else begin
                m_frozen <= 0;
                if (ex_branch_taken)  m_fl <= m_fl + 1;
                else if (model_lu())  m_lu <= m_lu + 1;
            end
        end
    end

    task automatic drive_idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_memread = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drive_idle();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_out !== IDLE_PAT) begin
            errors++;
            $display("FAIL reset_asserted got=%b exp=%b", dut_out, IDLE_PAT);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (dut_out !== IDLE_PAT) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", dut_out, IDLE_PAT);
        end
`ifdef HAZ_STATS_EN
        checks++;
        if ({lu_cnt, flush_cnt, memwait_cnt} !== 48'd0) begin
            errors++;
            $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", lu_cnt, flush_cnt, memwait_cnt);
        end
`endif
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        #1;
        checks++;
        if (dut_out !== LU_PAT) begin
            errors++;
            $display("FAIL lu_rs_bubble got=%b exp=%b", dut_out, LU_PAT);
        end
        // Bubble now sits in EX, so its memread is zero.
        @(negedge clk);
        ex_memread = 1'b0; ex_rt = 5'd0;
        #1;
        checks++;
        if (dut_out !== IDLE_PAT) begin
            errors++;
            $display("FAIL lu_after_bubble got=%b exp=%b", dut_out, IDLE_PAT);
        end
        @(negedge clk);
        drive_idle();
        ex_memread = 1'b1; ex_rt = 5'd17; id_rt = 5'd17; id_uses_rt = 1'b1; id_rs = 5'd17;
        #1;
        checks++;
        if (dut_out !== LU_PAT) begin
            errors++;
            $display("FAIL lu_rt_bubble got=%b exp=%b", dut_out, LU_PAT);
        end
        @(negedge clk);
        id_uses_rt = 1'b0;
        #1;
        checks++;
        if (dut_out !== IDLE_PAT) begin
            errors++;
            $display("FAIL lu_unused_field got=%b exp=%b", dut_out, IDLE_PAT);
        end
`ifdef HAZ_STATS_EN
        checks++;
        if (lu_cnt !== 16'd2) begin
            errors++;
            $display("FAIL lu_cnt got=%0d exp=2", lu_cnt);
        end
`endif
        $display("test_load_use done");
    endtask

    task automatic test_rt_zero();
        do_reset();
        @(negedge clk);
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        #1;
        checks++;
        if (dut_out !== IDLE_PAT) begin
            errors++;
            $display("FAIL rt_zero_no_stall got=%b exp=%b", dut_out, IDLE_PAT);
        end
        $display("test_rt_zero done");
    endtask

    task automatic test_branch_lu();
        do_reset();
        @(negedge clk);
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1; ex_branch_taken = 1'b1;
        #1;
        checks++;
        if (dut_out !== FLUSH_PAT) begin
            errors++;
            $display("FAIL branch_beats_lu got=%b exp=%b", dut_out, FLUSH_PAT);
        end
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (dut_out !== IDLE_PAT) begin
            errors++;
            $display("FAIL branch_then_idle got=%b exp=%b", dut_out, IDLE_PAT);
        end
`ifdef HAZ_STATS_EN
        checks++;
        if ({flush_cnt, lu_cnt} !== {16'd1, 16'd0}) begin
            errors++;
            $display("FAIL branch_counters got=%0d/%0d exp=1/0", flush_cnt, lu_cnt);
        end
`endif
        $display("test_branch_lu done");
    endtask

    task automatic test_mem_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
            #1;
            checks++;
            if (dut_out !== FREEZE_PAT) begin
                errors++;
                $display("FAIL stall_cycle%0d got=%b exp=%b", i, dut_out, FREEZE_PAT);
            end
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        checks++;
        if (dut_out !== FLUSH_PAT) begin
            errors++;
            $display("FAIL stall_release_branch got=%b exp=%b", dut_out, FLUSH_PAT);
        end
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (dut_out !== IDLE_PAT) begin
            errors++;
            $display("FAIL stall_back_to_run got=%b exp=%b", dut_out, IDLE_PAT);
        end
`ifdef HAZ_STATS_EN
        checks++;
        if ({memwait_cnt, flush_cnt} !== {16'd3, 16'd1}) begin
            errors++;
            $display("FAIL stall_counters got=%0d/%0d exp=3/1", memwait_cnt, flush_cnt);
        end
`endif
        $display("test_mem_stall done");
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            mem_req = 1'b1; mem_ready = 1'b0;
            #1;
            checks++;
            if (dut_out !== FREEZE_PAT) begin
                errors++;
                $display("FAIL timeout_frozen%0d got=%b exp=%b", i, dut_out, FREEZE_PAT);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = (i != 0);
            mem_req   = (i != 2);
            #1;
            checks++;
            if (dut_out !== ERR_PAT) begin
                errors++;
                $display("FAIL timeout_err%0d got=%b exp=%b", i, dut_out, ERR_PAT);
            end
        end
        $display("test_timeout done");
    endtask

    task automatic test_reset_err();
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (dut_out !== ERR_PAT) begin
            errors++;
            $display("FAIL err_sticky got=%b exp=%b", dut_out, ERR_PAT);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_out !== IDLE_PAT) begin
            errors++;
            $display("FAIL reset_in_err got=%b exp=%b", dut_out, IDLE_PAT);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset_err done");
    endtask

    task automatic test_reset_memwait();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mem_req = 1'b1; mem_ready = 1'b0;
        end
        #1;
        drive_idle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_out !== IDLE_PAT) begin
            errors++;
            $display("FAIL reset_in_wait got=%b exp=%b", dut_out, IDLE_PAT);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (dut_out !== IDLE_PAT) begin
            errors++;
            $display("FAIL wait_reset_release got=%b exp=%b", dut_out, IDLE_PAT);
        end
`ifdef HAZ_STATS_EN
        checks++;
        if ({lu_cnt, flush_cnt, memwait_cnt} !== 48'd0) begin
            errors++;
            $display("FAIL wait_reset_counters got=%0d/%0d/%0d exp=0/0/0", lu_cnt, flush_cnt, memwait_cnt);
        end
`endif
        $display("test_reset_memwait done");
    endtask

    task automatic test_random();
        logic [6:0] exp;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (m_err) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rt           = 5'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_memread      = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_req         = ($urandom_range(0, 3) == 0) || (m_frozen != 0 && $urandom_range(0, 1) == 1);
            mem_ready       = ($urandom_range(0, 2) != 0);
            #1;
            exp = exp_out();
            checks++;
            if (dut_out !== exp) begin
                errors++;
                $display("FAIL rand_out cyc=%0d got=%b exp=%b", n, dut_out, exp);
            end
`ifdef HAZ_STATS_EN
            checks++;
            if ({lu_cnt, flush_cnt, memwait_cnt} !== {16'(m_lu), 16'(m_fl), 16'(m_mw)}) begin
                errors++;
                $display("FAIL rand_cnt cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                         n, lu_cnt, flush_cnt, memwait_cnt, m_lu, m_fl, m_mw);
            end
`endif
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rt_zero();
        test_branch_lu();
        test_mem_stall();
        test_timeout();
        test_reset_err();
        test_reset_memwait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that sequences the ID/EX pipeline register and its neighbours in the 5-stage MIPS core. It detects load-use hazards and inserts a bubble by zeroing the WB/M/EX control bundle entering ID/EX. It flushes IF/ID and ID/EX on a taken branch resolved in EX. It freezes the whole pipeline while a MEM-stage access waits on a ready handshake, with a timeout into a sticky error state.

## Interface
- MEM_TIMEOUT, 15: max consecutive MEM_WAIT cycles with mem_ready low before ERR; legal range 1..255
- CNT_W, 16: width of statistics counters (HAZ_STATS_EN only)
- clk_HC  in  1  pipeline clock, rising edge
- rst_n_HC  in  1  reset, asynchronous, active-low
- id_rs, id_rt  in  5 each  source register fields of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  instruction in ID reads rs / rt
- ex_memread  in  1  instruction in EX is a load (M bundle bit of ID/EX output)
- ex_rt  in  5  destination register of the instruction in EX
- ex_branch_taken  in  1  branch in EX resolved taken
- mem_req, mem_ready  in  1 each  MEM-stage access request / completion
- pc_write  out  1  PC may update
- ifid_write  out  1  IF/ID may load
- ifid_flush  out  1  IF/ID loads a NOP
- idex_bubble  out  1  ID/EX loads zero WB/M/EX controls
- idex_hold, exmem_hold  out  1 each  ID/EX and EX/MEM keep their contents
- err  out  1  sticky memory-timeout error
- lu_cnt, flush_cnt, memwait_cnt  out  CNT_W each  statistics (HAZ_STATS_EN only)

## Operation
- States: RUN, MEM_WAIT, ERR. State is registered. Outputs are a combinational decode of state plus inputs.
- lu = ex_memread & (ex_rt != 0) & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)).
- mstall = mem_req & ~mem_ready.
- Idle decode, used in RUN with no event: pc_write=1, ifid_write=1. All other control outputs are 0.
- RUN, in priority order:
  - mstall: freeze. pc_write=0, ifid_write=0, idex_hold=1, exmem_hold=1. Next state MEM_WAIT, wait_cnt=1.
  - ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1. The lu check is suppressed because the ID instruction is squashed.
  - lu: pc_write=0, ifid_write=0, idex_bubble=1. Exactly one bubble per hazard. The hazard clears naturally once the bubble occupies EX.
- MEM_WAIT:
  - mstall still true: freeze, wait_cnt++. If wait_cnt == MEM_TIMEOUT, next state is ERR.
  - Otherwise (mem_ready=1 or mem_req dropped): release. Apply the RUN branch/lu decode in the same cycle, then next state RUN.
- ERR: freeze permanently with err=1. Only reset exits.
- wait_cnt is $clog2(MEM_TIMEOUT+1) bits. It is cleared on entry to RUN.

## Timing
- Reset values: state=RUN, wait_cnt=0, err=0, all statistics counters 0. Outputs then follow the RUN decode.
- Reset assertion mid-MEM_WAIT or in ERR returns to RUN immediately, asynchronously.
- Zero-latency control: every output reacts in the same cycle as its causing inputs. State changes take effect at the next clk_HC edge.
- Load-use costs 1 cycle. Taken branch costs 2 squashed instructions. MEM stall lasts N+0 cycles for mem_ready arriving N cycles after the request.
- A branch and a load-use in the same cycle: the branch wins, no stall.
- mstall together with a branch: the freeze wins, and the branch is applied on the release cycle. Inputs stay stable because the pipeline is frozen.
- ERR is entered after exactly MEM_TIMEOUT frozen cycles without ready.

## Configuration
- HAZ_STATS_EN defined: three saturating CNT_W counters.
  - lu_cnt increments on each lu bubble.
  - flush_cnt increments on each branch flush.
  - memwait_cnt increments on each frozen cycle.
  - All three reset to 0 and saturate at all-ones.
- HAZ_STATS_EN undefined: the counters and their ports are absent. Control behaviour is identical.

## Structure
- hazard_pkg holds:
  - the state typedef (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2);
  - the register-zero constant;
  - the default MEM_TIMEOUT.
- One sub-module, hc_lu_cmp: combinational load-use comparator producing lu. It is reused by the forwarding-unit work.

## Test plan
- Load-use: ex_memread=1, ex_rt=8, id_rs=8, id_uses_rs=1 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1, then idle decode.
- ex_rt=0 with a matching id_rs=0 -> no stall.
- Branch plus lu in the same cycle: ex_branch_taken=1 -> ifid_flush=1, idex_bubble=1, pc_write=1, no stall. flush_cnt=1 with HAZ_STATS_EN.
- MEM stall: mem_req=1, mem_ready low for 3 cycles -> 3 frozen cycles (holds=1, pc_write=0). Release on the 4th cycle, then RUN. memwait_cnt=3.
- Timeout: MEM_TIMEOUT=4, mem_ready never rises -> ERR after 4 frozen cycles, err=1 held.
- Reset mid-ERR: rst_n_HC low -> RUN and err=0 asynchronously.
- Reset mid-MEM_WAIT -> RUN, counters 0, outputs at idle decode on deassertion.
